// File: rtl/clk_rst_ctrl.sv
// clk_rst_ctrl: clock/reset manager living on the PLL output clock.
// Synchronises and filters the PLL lock flag, holds the downstream reset
// until lock has been stable, then releases it and generates NUM_CH
// programmable clock-enable strobes. Lock loss re-asserts reset and the
// block re-acquires lock on its own.
// Optional feature macro: CLK_CTRL_LOSS_CNT_EN adds the loss_cnt port, a
// saturating count of RUN->LOST transitions.
module clk_rst_ctrl #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILT   = 16,
  parameter int RST_HOLD    = 32
`ifdef CLK_CTRL_LOSS_CNT_EN
  ,parameter int CNT_W      = 8
`endif
) (
  input  logic                    clk_in,
  input  logic                    resetb,
  input  logic                    pll_locked,
  input  logic [NUM_CH*DIV_W-1:0] div_cfg,
  output logic                    rst_out_n,
  output logic                    ready,
  output logic [1:0]              state_o,
  output logic [NUM_CH-1:0]       ce_out
`ifdef CLK_CTRL_LOSS_CNT_EN
  ,output logic [CNT_W-1:0]       loss_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'b00,
    ST_HOLD      = 2'b01,
    ST_RUN       = 2'b10,
    ST_LOST      = 2'b11
  } state_t;

  localparam int FILT_W = $clog2(LOCK_FILT + 1);
  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lock_s;
  state_t                 state_q, state_d;
  logic [FILT_W-1:0]      filt_cnt_q, filt_cnt_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [DIV_W-1:0]       div_cnt_q [NUM_CH];
  logic [DIV_W-1:0]       div_cnt_d [NUM_CH];
  logic [NUM_CH-1:0]      ce_q, ce_d;
  logic                   rst_n_q, rst_n_d;
  logic                   ready_q, ready_d;

  // Lock synchroniser: shift the raw flag through SYNC_STAGES flops.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pll_locked};
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // State register and all counters/outputs; everything clears on resetb.
  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      sync_q     <= '0;
      state_q    <= ST_WAIT_LOCK;
      filt_cnt_q <= '0;
      hold_cnt_q <= '0;
      ce_q       <= '0;
      rst_n_q    <= 1'b0;
      ready_q    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_cnt_q[i] <= '0;
      end
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      filt_cnt_q <= filt_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      ce_q       <= ce_d;
      rst_n_q    <= rst_n_d;
      ready_q    <= ready_d;
      for (int i = 0; i < NUM_CH; i++) begin
        div_cnt_q[i] <= div_cnt_d[i];
      end
    end
  end

  // Next-state logic; a lock_s drop always wins over filter/hold progress.
  always_comb begin
    state_d    = state_q;
    filt_cnt_d = '0;
    hold_cnt_d = '0;
    case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          if (filt_cnt_q == FILT_LAST) state_d = ST_HOLD;
          else                          filt_cnt_d = filt_cnt_q + FILT_W'(1);
        end
      end
      ST_HOLD: begin
        if (!lock_s)                       state_d = ST_WAIT_LOCK;
        else if (hold_cnt_q == HOLD_LAST)  state_d = ST_RUN;
        else                               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
      ST_RUN: begin
        if (!lock_s) state_d = ST_LOST;
      end
      ST_LOST: begin
        state_d = ST_WAIT_LOCK;
      end
      default: begin
        state_d = ST_WAIT_LOCK;
      end
    endcase
  end

  // Output logic: registered reset/ready from the next state, and the
  // clock-enable dividers. Divider counters sit at 0 outside RUN, so the
  // entry edge behaves like a pulse at cycle 0 and the first real pulse
  // lands on RUN cycle d. Using >= for the wrap keeps a shrinking divisor
  // from overshooting into a full-range wrap.
  always_comb begin
    rst_n_d = (state_d == ST_RUN);
    ready_d = (state_d == ST_RUN);
    ce_d    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      logic [DIV_W-1:0] div_val;
      logic             hit;
      div_val      = div_cfg[i*DIV_W +: DIV_W];
      hit          = ({1'b0, div_cnt_q[i]} + (DIV_W+1)'(1)) >= {1'b0, div_val};
      div_cnt_d[i] = '0;
      if (state_d == ST_RUN) begin
        ce_d[i]      = hit;
        div_cnt_d[i] = hit ? '0 : div_cnt_q[i] + DIV_W'(1);
      end
    end
  end

`ifdef CLK_CTRL_LOSS_CNT_EN
  logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;

  // Count RUN->LOST transitions, holding at the maximum value.
  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if ((state_q == ST_RUN) && (state_d == ST_LOST) && (loss_cnt_q != '1)) begin
      loss_cnt_d = loss_cnt_q + CNT_W'(1);
    end
  end

  // Loss counter register.
  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) loss_cnt_q <= '0;
    else         loss_cnt_q <= loss_cnt_d;
  end

  assign loss_cnt = loss_cnt_q;
`else
  // Loss counting disabled: no counter register and no loss_cnt port.
`endif

  assign rst_out_n = rst_n_q;
  assign ready     = ready_q;
  assign state_o   = state_q;
  assign ce_out    = ce_q;

endmodule

// File: tb/tb_clk_rst_ctrl.sv
// Bench for clk_rst_ctrl: directed scenarios followed by randomized lock
// activity and divisor changes, compared against a lock-streak reference
// model every cycle. Honours CLK_CTRL_LOSS_CNT_EN for the loss counter.
module tb_clk_rst_ctrl;

  localparam int NUM_CH      = 2;
  localparam int DIV_W       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int LOCK_FILT   = 16;
  localparam int RST_HOLD    = 32;
  localparam int ACQ_LAT     = SYNC_STAGES + LOCK_FILT + RST_HOLD;

  logic                    clk_in = 1'b0;
  logic                    resetb;
  logic                    pll_locked;
  logic [NUM_CH*DIV_W-1:0] div_cfg;
  logic                    rst_out_n;
  logic                    ready;
  logic [1:0]              state_o;
  logic [NUM_CH-1:0]       ce_out;
`ifdef CLK_CTRL_LOSS_CNT_EN
  logic [7:0]              loss_cnt;
`endif

  clk_rst_ctrl #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .SYNC_STAGES(SYNC_STAGES),
    .LOCK_FILT(LOCK_FILT), .RST_HOLD(RST_HOLD)
  ) dut (
    .clk_in(clk_in),
    .resetb(resetb),
    .pll_locked(pll_locked),
    .div_cfg(div_cfg),
    .rst_out_n(rst_out_n),
    .ready(ready),
    .state_o(state_o),
    .ce_out(ce_out)
`ifdef CLK_CTRL_LOSS_CNT_EN
    ,.loss_cnt(loss_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Reference model state: a lock_s history, the length of the current
  // unbroken lock streak, the RUN cycle index and the last pulse cycle of
  // each channel.
  logic [SYNC_STAGES-1:0] hist = '0;
  int                     m_state = 0;
  int                     streak = 0;
  int                     run_k = 0;
  int                     last_pulse [NUM_CH];
  logic [NUM_CH-1:0]      m_ce = '0;
`ifdef CLK_CTRL_LOSS_CNT_EN
  int                     m_loss = 0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the reference model, sampled at the rising edge.
  task automatic model_step();
    logic ls;
    int   prev;
    int   d;
    if (!resetb) begin
      hist    = '0;
      m_state = 0;
      streak  = 0;
      run_k   = 0;
      m_ce    = '0;
      for (int c = 0; c < NUM_CH; c++) last_pulse[c] = 0;
`ifdef CLK_CTRL_LOSS_CNT_EN
      m_loss  = 0;
`endif
    end else begin
      ls   = hist[SYNC_STAGES-1];
      hist = {hist[SYNC_STAGES-2:0], pll_locked};
      prev = m_state;
      if (prev == 3) begin
        m_state = 0;
        streak  = 0;
      end else if (!ls) begin
        m_state = (prev == 2) ? 3 : 0;
        streak  = 0;
`ifdef CLK_CTRL_LOSS_CNT_EN
        if (prev == 2 && m_loss < 255) m_loss++;
`endif
      end else begin
        streak++;
        if (streak >= LOCK_FILT + RST_HOLD) m_state = 2;
        else if (streak >= LOCK_FILT)       m_state = 1;
        else                                m_state = 0;
      end
      m_ce = '0;
      if (m_state == 2) begin
        if (prev != 2) begin
          run_k = 1;
          for (int c = 0; c < NUM_CH; c++) last_pulse[c] = 0;
        end else begin
          run_k++;
        end
        for (int c = 0; c < NUM_CH; c++) begin
          d = int'(div_cfg[c*DIV_W +: DIV_W]);
          if (run_k - last_pulse[c] >= d) begin
            m_ce[c]       = 1'b1;
            last_pulse[c] = run_k;
          end
        end
      end
    end
  endtask

  // Advance one cycle, then compare all outputs against the model.
  task automatic tick();
    logic [1:0] ms;
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
    ms = 2'(m_state);
    chk("cycle", 32'({state_o, rst_out_n, ready, ce_out}),
                 32'({ms, (m_state == 2), (m_state == 2), m_ce}));
`ifdef CLK_CTRL_LOSS_CNT_EN
    chk("loss_model", 32'(loss_cnt), 32'(m_loss));
`endif
  endtask

  task automatic wait_rst(input logic lvl, input int limit, output int n);
    n = 0;
    while (rst_out_n !== lvl && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    resetb = 1'b0;
    tick();
    tick();
    resetb = 1'b1;
  endtask

  initial begin
    int n;
    resetb     = 1'b0;
    pll_locked = 1'b1;
    div_cfg    = {8'd4, 8'd0};

    // Reset held with the PLL already locked.
    repeat (3) tick();
    chk("rst_rst_out_n", 32'(rst_out_n), 32'd0);
    chk("rst_ready",     32'(ready),     32'd0);
    chk("rst_ce_out",    32'(ce_out),    32'd0);
    chk("rst_state",     32'(state_o),   32'd0);

    // Acquire latency from resetb release.
    resetb = 1'b1;
    wait_rst(1'b1, 200, n);
    chk("acq_latency", 32'(n), 32'(ACQ_LAT));
    chk("acq_state", 32'(state_o), 32'd2);
    chk("acq_ready", 32'(ready), 32'd1);

    // Divisors 0 and 4: channel 0 every cycle, channel 1 on cycles 4/8/12.
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) tick();
      chk("ce0_div0", 32'(ce_out[0]), 32'd1);
      chk("ce1_div4", 32'(ce_out[1]), 32'((k % 4) == 0));
    end

    // Divisor 10, then shrink to 3 while the counter is at 7.
    div_cfg[15:8] = 8'd10;
    for (int k = 13; k <= 19; k++) begin
      tick();
      chk("ce1_div10", 32'(ce_out[1]), 32'd0);
    end
    div_cfg[15:8] = 8'd3;
    for (int k = 20; k <= 26; k++) begin
      tick();
      chk("ce1_shrink", 32'(ce_out[1]), 32'(k == 20 || k == 23 || k == 26));
    end

    // Lock loss in RUN.
    pll_locked = 1'b0;
    wait_rst(1'b0, 20, n);
    chk("loss_latency", 32'(n), 32'(SYNC_STAGES + 1));
    chk("lost_state", 32'(state_o), 32'd3);
    chk("lost_ready", 32'(ready), 32'd0);
    chk("lost_ce", 32'(ce_out), 32'd0);
    tick();
    chk("lost_to_wait", 32'(state_o), 32'd0);
`ifdef CLK_CTRL_LOSS_CNT_EN
    chk("loss_cnt_one", 32'(loss_cnt), 32'd1);
`endif

    // Re-lock.
    pll_locked = 1'b1;
    wait_rst(1'b1, 200, n);
    chk("relock_latency", 32'(n), 32'(ACQ_LAT));

    // Asynchronous reset mid-cycle in RUN.
    repeat (5) tick();
    #2 resetb = 1'b0;
    #1;
    chk("async_rst", 32'({state_o, rst_out_n, ready, ce_out}), 32'd0);
    @(negedge clk_in);
    tick();

    // Lock glitch of 3 cycles when the filter count reaches 10.
    pll_locked = 1'b1;
    resetb     = 1'b1;
    repeat (SYNC_STAGES + 10) tick();
    pll_locked = 1'b0;
    repeat (3) tick();
    pll_locked = 1'b1;
    wait_rst(1'b1, 200, n);
    chk("glitch_latency", 32'(n), 32'(ACQ_LAT));

    // Lock drop during HOLD returns to WAIT_LOCK without a loss event.
    do_reset();
    repeat (30) tick();
    chk("hold_state", 32'(state_o), 32'd1);
    pll_locked = 1'b0;
    repeat (SYNC_STAGES + 1) tick();
    chk("hold_drop_state", 32'(state_o), 32'd0);
    chk("hold_drop_rst", 32'(rst_out_n), 32'd0);
`ifdef CLK_CTRL_LOSS_CNT_EN
    chk("hold_drop_loss", 32'(loss_cnt), 32'd0);
`endif

    // Randomized lock activity and divisor updates.
    for (int seg = 0; seg < 40; seg++) begin
      if (seg == 20) do_reset();
      for (int c = 0; c < NUM_CH; c++) div_cfg[c*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 9));
      pll_locked = 1'b1;
      repeat ($urandom_range(20, 140)) begin
        if ($urandom_range(0, 15) == 0)
          div_cfg[$urandom_range(0, NUM_CH-1)*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 12));
        tick();
      end
      pll_locked = 1'b0;
      repeat ($urandom_range(1, 5)) tick();
    end

    if (failed != 0) $display("%0d checks did not match", failed);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/clk_rst_ctrl.md
Name: clk_rst_ctrl

Overview:
Parametrised clock/reset manager placed on the PLL output clock domain. It filters the asynchronous PLL lock flag and holds the design reset until lock has been stable. It then releases a synchronised reset and drives NUM_CH runtime-programmable clock-enable strobes for slower logic. It also detects lock loss, re-asserts reset and re-acquires lock automatically.

Parameters:
NUM_CH, 2, number of clock-enable channels (>=1)
DIV_W, 8, width of each channel divisor
SYNC_STAGES, 2, flops in the pll_locked synchroniser (>=2)
LOCK_FILT, 16, consecutive synchronised lock samples required before the hold phase (>=1)
RST_HOLD, 32, cycles rst_out_n stays low after the lock filter passes (>=1)
CNT_W, 8, width of the lock-loss counter (optional feature only)

Ports:
clk_in  input  1  PLL output clock; the only clock
resetb  input  1  asynchronous active-low reset
pll_locked  input  1  raw PLL lock flag, asynchronous to clk_in
div_cfg  input  NUM_CH*DIV_W  channel i divisor d_i = div_cfg[i*DIV_W +: DIV_W]
rst_out_n  output  1  synchronous-deassert active-low reset to downstream logic, registered
ready  output  1  high exactly while state is RUN, registered
state_o  output  2  FSM state: 00 WAIT_LOCK, 01 HOLD, 10 RUN, 11 LOST
ce_out  output  NUM_CH  one-cycle clock-enable strobes, registered
loss_cnt  output  CNT_W  saturating count of lock losses from RUN (only with CLK_CTRL_LOSS_CNT_EN)

Behaviour:
- resetb low, asynchronously: synchroniser flops=0, state=WAIT_LOCK, rst_out_n=0, ready=0, ce_out=0, filter/hold/divider counters=0, loss_cnt=0.
- lock_s is the output of the last synchroniser flop. It reflects pll_locked after SYNC_STAGES edges.
- WAIT_LOCK: the filter counter increments on each edge with lock_s=1 and clears on lock_s=0. On the LOCK_FILT-th consecutive lock_s=1 sample, go to HOLD and clear the counter.
- HOLD: rst_out_n=0. The hold counter counts edges. If lock_s=0, go to WAIT_LOCK; this is not a loss event. After RST_HOLD edges, go to RUN.
- RUN: rst_out_n=1 and ready=1, set on the edge entering RUN. If lock_s=0, go to LOST.
- LOST: rst_out_n=0, ready=0 and ce_out=0 on the edge entering LOST. Lasts exactly one cycle, then WAIT_LOCK.
- Acquire latency: with pll_locked stable high, rst_out_n rises SYNC_STAGES+LOCK_FILT+RST_HOLD edges after the first edge sampling pll_locked=1. Defaults: 50 edges.
- Loss latency: rst_out_n falls SYNC_STAGES+1 edges after the first edge sampling pll_locked=0.
- Dividers run only in RUN. All counters reset to 0 on entering RUN; ce_out=0 in every other state.
- d_i of 0 or 1: ce_out[i]=1 on every RUN cycle, including the first.
- d_i>=2: ce_out[i] is high exactly one cycle in every d_i cycles. The first pulse is on the d_i-th cycle with rst_out_n=1.
- Divider counters are DIV_W wide. A channel pulses and wraps to 0 when its counter >= d_i-1, so a runtime decrease of d_i never causes a 2^DIV_W-cycle run-away. div_cfg is sampled every cycle.
- Simultaneous events: a lock_s drop always takes priority over a divider pulse or hold expiry in the same cycle. In that case the pulse and the RUN transition are suppressed.
- resetb asserted in any state aborts immediately to the reset values above; no partial outputs.

Optional Feature:
CLK_CTRL_LOSS_CNT_EN
- Defined: the loss_cnt port exists. It increments by 1 on each RUN->LOST transition and saturates at 2^CNT_W-1.
- Undefined: the loss_cnt port and its register are absent. All other behaviour is identical.

Test Plan:
- resetb low with pll_locked=1 -> rst_out_n=0, ready=0, ce_out=0, state_o=00. Release resetb -> rst_out_n rises exactly 50 edges later (defaults).
- Lock glitch: pll_locked low for 3 cycles when the filter count reaches 10 -> filter restarts; rst_out_n rises 50 edges after pll_locked returns high.
- Lock drop during HOLD -> state_o returns to 00, rst_out_n stays 0, loss_cnt stays 0.
- pll_locked falls in RUN -> rst_out_n=0 at edge 3, state_o=11 for 1 cycle then 00, loss_cnt=1. Re-lock -> RUN after 50 edges.
- div_cfg={8'd4,8'd0} in RUN -> ce_out[0] high every cycle; ce_out[1] high on RUN cycles 4, 8, 12.
- Change d from 10 to 3 while counter=7 -> pulse on the next cycle, then every 3 cycles.
